cpu_mem_bridge: RTL

- Downstream neighbour of the cpu core; consumes its address / write data / rw bus.
- Turns each CPU access into a req/ack handshake towards a slower external memory or peripheral bus.
- Returns read data with a one-cycle `cpu_ready` strobe.
- Adds a one-entry last-read buffer for single-cycle repeat reads, plus a watchdog that terminates hung accesses with an error pulse.

---
 rtl/cpu_mem_bridge.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cpu_mem_bridge.sv
// CPU-to-memory bridge: turns CPU accesses into a req/ack handshake, with a
// one-entry last-read buffer for repeat reads and a watchdog that aborts hung accesses.
module cpu_mem_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15,
   parameter int HIT_EN  = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_valid,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_rw,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              cpu_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t            r_state, w_state_nxt;
   logic              r_mem_req, w_mem_req_nxt;
   logic              r_mem_we, w_mem_we_nxt;
   logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
   logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
   logic [DATA_W-1:0] r_cpu_rdata, w_cpu_rdata_nxt;
   logic              r_cpu_ready, w_cpu_ready_nxt;
   logic              r_cpu_err, w_cpu_err_nxt;
   logic [7:0]        r_cnt, w_cnt_nxt;
   logic              r_buf_vld, w_buf_vld_nxt;
   logic [ADDR_W-1:0] r_buf_tag, w_buf_tag_nxt;
   logic [DATA_W-1:0] r_buf_data, w_buf_data_nxt;
   logic              w_hit;

   assign w_hit = cpu_valid && cpu_rw && (HIT_EN != 0) && r_buf_vld && (cpu_addr == r_buf_tag);

   always_comb begin
      w_state_nxt     = r_state;
      w_mem_req_nxt   = r_mem_req;
      w_mem_we_nxt    = r_mem_we;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_cpu_rdata_nxt = r_cpu_rdata;
      w_cpu_ready_nxt = 1'b0;
      w_cpu_err_nxt   = 1'b0;
      w_cnt_nxt       = r_cnt;
      w_buf_vld_nxt   = r_buf_vld;
      w_buf_tag_nxt   = r_buf_tag;
      w_buf_data_nxt  = r_buf_data;

      case (r_state)
         IDLE: begin
            if (w_hit) begin
               w_state_nxt     = RESP;
               w_cpu_ready_nxt = 1'b1;
               w_cpu_rdata_nxt = r_buf_data;
            end else if (cpu_valid) begin
               w_state_nxt     = REQ;
               w_mem_req_nxt   = 1'b1;
               w_mem_we_nxt    = ~cpu_rw;
               w_mem_addr_nxt  = cpu_addr;
               w_mem_wdata_nxt = cpu_wdata;
               w_cnt_nxt       = 8'd0;
            end
         end
         REQ: begin
            // Ack takes priority over the watchdog when both land on the same edge.
            if (mem_ack) begin
               w_state_nxt     = RESP;
               w_mem_req_nxt   = 1'b0;
               w_cpu_ready_nxt = 1'b1;
               if (!r_mem_we) begin
                  w_cpu_rdata_nxt = mem_rdata;
                  w_buf_vld_nxt   = 1'b1;
                  w_buf_tag_nxt   = r_mem_addr;
                  w_buf_data_nxt  = mem_rdata;
               end else if (r_buf_vld && (r_buf_tag == r_mem_addr)) begin
                  w_buf_data_nxt  = r_mem_wdata;
               end
            end else if (r_cnt == TO_LAST) begin
               w_state_nxt     = RESP;
               w_mem_req_nxt   = 1'b0;
               w_cpu_ready_nxt = 1'b1;
               w_cpu_err_nxt   = 1'b1;
               w_cpu_rdata_nxt = '0;
               w_buf_vld_nxt   = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         RESP: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt   = IDLE;
            w_mem_req_nxt = 1'b0;
         end
      endcase

      if (HIT_EN == 0) w_buf_vld_nxt = 1'b0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_cpu_rdata <= '0;
         r_cpu_ready <= 1'b0;
         r_cpu_err   <= 1'b0;
         r_cnt       <= 8'd0;
         r_buf_vld   <= 1'b0;
         r_buf_tag   <= '0;
         r_buf_data  <= '0;
      end else begin
         r_mem_req   <= w_mem_req_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_cpu_rdata <= w_cpu_rdata_nxt;
         r_cpu_ready <= w_cpu_ready_nxt;
         r_cpu_err   <= w_cpu_err_nxt;
         r_cnt       <= w_cnt_nxt;
         r_buf_vld   <= w_buf_vld_nxt;
         r_buf_tag   <= w_buf_tag_nxt;
         r_buf_data  <= w_buf_data_nxt;
      end
   end

   assign cpu_rdata = r_cpu_rdata;
   assign cpu_ready = r_cpu_ready;
   assign cpu_err   = r_cpu_err;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule
